zbreak: RTL and testbench

- Z80 bus breakpoint unit. Sits directly upstream of the NMI generator and drives its immediate-NMI (imm_nmi) input.
- Holds NUM_BP address comparators, programmed through zports strobes. Each comparator matches opcode fetches, memory reads or memory writes.
- On a match it raises imm_nmi, then locks out until the NMI handler exits (in_nmi falls). After exit it steps over the first M1 fetch so the return instruction does not re-trigger.

---
 rtl/zbreak.sv | 212 +++++++++++++++++++++
 tb/tb_zbreak.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbreak.sv
// rtl/zbreak.sv - Z80 bus breakpoint unit driving the NMI generator's imm_nmi input
// Optional feature macro: ZBREAK_PASSCNT_EN (per-slot pass counts, adds wr_pcnt port).
module zbreak #(
  parameter int NUM_BP   = 2,
  parameter int FIRE_TMO = 15
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] a,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        in_nmi,
  input  logic [1:0]  bp_idx,
  input  logic [7:0]  din,
  input  logic        wr_alo,
  input  logic        wr_ahi,
  input  logic        wr_ctl,
  input  logic        clr_hit,
`ifdef ZBREAK_PASSCNT_EN
  input  logic        wr_pcnt,
`endif
  output logic        imm_nmi,
  output logic        hit_valid,
  output logic [1:0]  hit_idx,
  output logic        busy
);

  localparam logic [1:0] TYPE_EXEC = 2'b01;
  localparam logic [1:0] TYPE_RD   = 2'b10;
  localparam logic [1:0] TYPE_WR   = 2'b11;
  localparam int         CW        = (FIRE_TMO < 2) ? 1 : $clog2(FIRE_TMO + 1);

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_EXIT,
    ST_STEP
  } state_t;

  state_t              state_q, state_d;

  // slot configuration
  logic [15:0]         addr_q [NUM_BP];
  logic [1:0]          type_q [NUM_BP];
`ifdef ZBREAK_PASSCNT_EN
  logic [7:0]          pcnt_q [NUM_BP];
`endif

  // bus sampling and cycle qualifiers
  logic                m1_n_q, mreq_n_q, rd_n_q, wr_n_q;
  logic                cyc_m1, cyc_rd, cyc_wr;
  logic                cyc_m1_q, cyc_rd_q, cyc_wr_q;
  logic                ev_m1, ev_rd, ev_wr;

  // match evaluation
  logic [NUM_BP-1:0]   slot_match;
  logic [NUM_BP-1:0]   slot_fire;
  logic [1:0]          fire_idx;
  logic                eval_en;
  logic                fire_req;

  logic [CW-1:0]       cnt_q;
  logic                hit_valid_q;
  logic [1:0]          hit_idx_q;

  // Latch M1 on the Z80 rising edge and the strobes on the falling edge
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_n_q   <= 1'b1;
      mreq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      if (zpos) m1_n_q <= m1_n;
      if (zneg) begin
        mreq_n_q <= mreq_n;
        rd_n_q   <= rd_n;
        wr_n_q   <= wr_n;
      end
    end
  end

  // Decode bus cycle kinds and flag their first fclk as a single event
  always_comb begin
    cyc_m1 = !m1_n_q && !mreq_n_q;
    cyc_rd = m1_n_q && !mreq_n_q && !rd_n_q;
    cyc_wr = !mreq_n_q && !wr_n_q;
    ev_m1  = cyc_m1 && !cyc_m1_q;
    ev_rd  = cyc_rd && !cyc_rd_q;
    ev_wr  = cyc_wr && !cyc_wr_q;
  end

  // Delayed qualifier copies for edge detection
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_m1_q <= 1'b0;
      cyc_rd_q <= 1'b0;
      cyc_wr_q <= 1'b0;
    end else begin
      cyc_m1_q <= cyc_m1;
      cyc_rd_q <= cyc_rd;
      cyc_wr_q <= cyc_wr;
    end
  end

  // Compare every slot against the event; lowest firing slot wins
  always_comb begin
    slot_match = '0;
    slot_fire  = '0;
    fire_idx   = 2'd0;
    for (int i = 0; i < NUM_BP; i++) begin
      slot_match[i] = (a == addr_q[i]) &&
                      (((type_q[i] == TYPE_EXEC) && ev_m1) ||
                       ((type_q[i] == TYPE_RD)   && ev_rd) ||
                       ((type_q[i] == TYPE_WR)   && ev_wr));
`ifdef ZBREAK_PASSCNT_EN
      slot_fire[i]  = slot_match[i] && (pcnt_q[i] == 8'd0);
`else
      slot_fire[i]  = slot_match[i];
`endif
    end
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_fire[i]) fire_idx = 2'(i);
    end
    eval_en  = (state_q == ST_ARMED) && !in_nmi;
    fire_req = eval_en && (|slot_fire);
  end

  // Slot programming; evaluation above always sees the pre-write values
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= 16'h0000;
        type_q[i] <= 2'b00;
`ifdef ZBREAK_PASSCNT_EN
        pcnt_q[i] <= 8'd0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_alo && (bp_idx == 2'(i))) addr_q[i][7:0]  <= din;
        if (wr_ahi && (bp_idx == 2'(i))) addr_q[i][15:8] <= din;
        if (wr_ctl && (bp_idx == 2'(i))) type_q[i]       <= din[1:0];
`ifdef ZBREAK_PASSCNT_EN
        if (wr_pcnt && (bp_idx == 2'(i))) begin
          pcnt_q[i] <= din;
        end else if (eval_en && slot_match[i] && (pcnt_q[i] != 8'd0)) begin
          pcnt_q[i] <= pcnt_q[i] - 8'd1;
        end
`endif
      end
    end
  end

  // Fire timeout: preloaded outside FIRE, counts zpos ticks while firing
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(FIRE_TMO);
    end else if (state_q != ST_FIRE) begin
      cnt_q <= CW'(FIRE_TMO);
    end else if (zpos && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Hit status; a new hit overrides a simultaneous clear
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid_q <= 1'b0;
      hit_idx_q   <= 2'd0;
    end else if (fire_req) begin
      hit_valid_q <= 1'b1;
      hit_idx_q   <= fire_idx;
    end else if (clr_hit) begin
      hit_valid_q <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ARMED;
    else        state_q <= state_d;
  end

  // FSM next state: fire, wait for handler, skip the return fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:     if (fire_req) state_d = ST_FIRE;
      ST_FIRE: begin
        if (in_nmi)              state_d = ST_WAIT_EXIT;
        else if (cnt_q == '0)    state_d = ST_ARMED;
      end
      ST_WAIT_EXIT: if (!in_nmi) state_d = ST_STEP;
      ST_STEP:      if (ev_m1)   state_d = ST_ARMED;
      default:                   state_d = ST_ARMED;
    endcase
  end

  // FSM outputs; imm_nmi is decoded from state so reset drops it at once
  always_comb begin
    imm_nmi   = (state_q == ST_FIRE);
    busy      = (state_q != ST_ARMED);
    hit_valid = hit_valid_q;
    hit_idx   = hit_idx_q;
  end

endmodule

// File: tb/tb_zbreak.sv
// tb/tb_zbreak.sv - scoreboard bench for zbreak
`timescale 1ns/1ps
module tb_zbreak;

  localparam int NUM_BP   = 2;
  localparam int FIRE_TMO = 15;

  logic        fclk = 1'b0;
  logic        rst_n, zpos, zneg, m1_n, mreq_n, rd_n, wr_n, in_nmi;
  logic [15:0] a;
  logic [1:0]  bp_idx;
  logic [7:0]  din;
  logic        wr_alo, wr_ahi, wr_ctl, clr_hit;
`ifdef ZBREAK_PASSCNT_EN
  logic        wr_pcnt;
`endif
  logic        imm_nmi, hit_valid, busy;
  logic [1:0]  hit_idx;

  always #5 fclk = ~fclk;

  zbreak #(.NUM_BP(NUM_BP), .FIRE_TMO(FIRE_TMO)) dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .a(a),
    .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .in_nmi(in_nmi),
    .bp_idx(bp_idx), .din(din), .wr_alo(wr_alo), .wr_ahi(wr_ahi),
    .wr_ctl(wr_ctl), .clr_hit(clr_hit),
`ifdef ZBREAK_PASSCNT_EN
    .wr_pcnt(wr_pcnt),
`endif
    .imm_nmi(imm_nmi), .hit_valid(hit_valid), .hit_idx(hit_idx), .busy(busy)
  );

  typedef struct packed {
    logic       fire;
    logic [1:0] idx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_addr [4];
  logic [1:0]  m_type [4];
  logic [7:0]  m_pcnt [4];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input bit zp, input bit zn);
    zpos = zp;
    zneg = zn;
    @(posedge fclk);
    #1;
    zpos = 1'b0;
    zneg = 1'b0;
  endtask

  task automatic strobe_cfg(input int sel, input logic [7:0] d);
    din = d;
    case (sel)
      0: wr_alo = 1'b1;
      1: wr_ahi = 1'b1;
      default: wr_ctl = 1'b1;
    endcase
    @(posedge fclk);
    #1;
    wr_alo = 1'b0;
    wr_ahi = 1'b0;
    wr_ctl = 1'b0;
  endtask

  task automatic cfg(input int idx, input logic [15:0] ad, input logic [1:0] ty);
    bp_idx = 2'(idx);
    strobe_cfg(0, ad[7:0]);
    strobe_cfg(1, ad[15:8]);
    strobe_cfg(2, {6'b0, ty});
    if (idx < NUM_BP) begin
      m_addr[idx] = ad;
      m_type[idx] = ty;
    end
  endtask

`ifdef ZBREAK_PASSCNT_EN
  task automatic pcnt(input int idx, input logic [7:0] n);
    bp_idx  = 2'(idx);
    din     = n;
    wr_pcnt = 1'b1;
    @(posedge fclk);
    #1;
    wr_pcnt = 1'b0;
    if (idx < NUM_BP) m_pcnt[idx] = n;
  endtask
`endif

  // Reference behaviour: kind 0 = M1 fetch, 1 = read, 2 = write
  task automatic model(input int kind, input logic [15:0] ad, input bit armed, output exp_t e);
    logic [1:0] want;
    want  = (kind == 0) ? 2'b01 : ((kind == 1) ? 2'b10 : 2'b11);
    e     = '0;
    if (!armed) return;
    for (int i = 0; i < NUM_BP; i++) begin
      if (m_type[i] == want && m_addr[i] == ad) begin
        if (m_pcnt[i] != 8'd0) begin
          m_pcnt[i] = m_pcnt[i] - 8'd1;
          continue;
        end
        if (!e.fire) begin
          e.fire = 1'b1;
          e.idx  = 2'(i);
        end
      end
    end
  endtask

  task automatic bus(input string tag, input int kind, input logic [15:0] ad,
                     input bit armed, input bit clr);
    exp_t       e;
    logic       imm_n, imm_n1;
    logic [1:0] hi;
    model(kind, ad, armed, e);
    sb.push_back(e);
    a = ad;
    if (kind == 0) begin
      m1_n = 1'b0;
      tick(1, 0);
    end
    mreq_n = 1'b0;
    if (kind == 2) wr_n = 1'b0;
    else           rd_n = 1'b0;
    tick(0, 1);
    @(negedge fclk);
    imm_n   = imm_nmi;
    clr_hit = clr;
    @(posedge fclk);
    #1;
    clr_hit = 1'b0;
    @(negedge fclk);
    imm_n1 = imm_nmi;
    hi     = hit_idx;
    e = sb.pop_front();
    check({tag, " imm@N"}, 32'(imm_n), 32'd0);
    check({tag, " imm@N+1"}, 32'(imm_n1), 32'(e.fire));
    if (e.fire) check({tag, " hit_idx"}, 32'(hi), 32'(e.idx));
    tick(0, 0);
    tick(0, 0);
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    tick(0, 1);
    m1_n = 1'b1;
    tick(1, 0);
  endtask

  task automatic recover(input string tag);
    in_nmi = 1'b1;
    tick(0, 0);
    @(negedge fclk);
    check({tag, " ack imm"}, 32'(imm_nmi), 32'd0);
    check({tag, " ack busy"}, 32'(busy), 32'd1);
    in_nmi = 1'b0;
    tick(0, 0);
    tick(0, 0);
    @(negedge fclk);
    check({tag, " step busy"}, 32'(busy), 32'd1);
    bus({tag, " step"}, 0, 16'h8000, 1'b0, 1'b0);
    @(negedge fclk);
    check({tag, " rearmed"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0;
      m_type[i] = '0;
      m_pcnt[i] = '0;
    end
    rst_n = 1'b0; zpos = 1'b0; zneg = 1'b0; a = '0;
    m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; in_nmi = 1'b0;
    bp_idx = '0; din = '0; wr_alo = 1'b0; wr_ahi = 1'b0; wr_ctl = 1'b0; clr_hit = 1'b0;
`ifdef ZBREAK_PASSCNT_EN
    wr_pcnt = 1'b0;
`endif
    repeat (3) tick(0, 0);
    rst_n = 1'b1;
    tick(0, 0);
    @(negedge fclk);
    check("rst imm_nmi", 32'(imm_nmi), 32'd0);
    check("rst hit_valid", 32'(hit_valid), 32'd0);
    check("rst hit_idx", 32'(hit_idx), 32'd0);
    check("rst busy", 32'(busy), 32'd0);

    // exec breakpoint, near miss then hit
    cfg(0, 16'h8000, 2'b01);
    bus("exec miss", 0, 16'h8001, 1'b1, 1'b0);
    bus("exec hit", 0, 16'h8000, 1'b1, 1'b0);
    check("exec hit_valid", 32'(hit_valid), 32'd1);
    recover("r1");
    bus("exec after step", 0, 16'h8000, 1'b1, 1'b0);
    recover("r2");

    // write breakpoint: read ignored, write fires
    cfg(1, 16'h5B00, 2'b11);
    bus("wr-bp read", 1, 16'h5B00, 1'b1, 1'b0);
    bus("wr-bp write", 2, 16'h5B00, 1'b1, 1'b0);
    recover("r3");

    // out-of-range slot write is dropped
    cfg(2, 16'h1234, 2'b01);
    bus("bad slot", 0, 16'h1234, 1'b1, 1'b0);

    // timeout with in_nmi held low
    bus("tmo fire", 0, 16'h8000, 1'b1, 1'b0);
    repeat (FIRE_TMO - 2) tick(1, 0);
    @(negedge fclk);
    check("tmo held", 32'(imm_nmi), 32'd1);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    @(negedge fclk);
    check("tmo imm", 32'(imm_nmi), 32'd0);
    check("tmo busy", 32'(busy), 32'd0);
    check("tmo hit_valid", 32'(hit_valid), 32'd1);

    // clear, then priority plus clear-vs-hit collision
    clr_hit = 1'b1;
    tick(0, 0);
    clr_hit = 1'b0;
    @(negedge fclk);
    check("clr hit_valid", 32'(hit_valid), 32'd0);
    cfg(0, 16'h4000, 2'b10);
    cfg(1, 16'h4000, 2'b10);
    bus("prio read", 1, 16'h4000, 1'b1, 1'b1);
    check("prio hit_valid", 32'(hit_valid), 32'd1);
    recover("r4");

    // match while handler already active is ignored
    in_nmi = 1'b1;
    bus("in_nmi read", 1, 16'h4000, 1'b0, 1'b0);
    in_nmi = 1'b0;
    tick(0, 0);
    @(negedge fclk);
    check("in_nmi busy", 32'(busy), 32'd0);

`ifdef ZBREAK_PASSCNT_EN
    cfg(0, 16'h8000, 2'b01);
    pcnt(0, 8'd2);
    bus("pass1", 0, 16'h8000, 1'b1, 1'b0);
    bus("pass2", 0, 16'h8000, 1'b1, 1'b0);
    bus("pass3", 0, 16'h8000, 1'b1, 1'b0);
    recover("r5");
`endif

    // asynchronous reset in the middle of FIRE
    cfg(0, 16'h8000, 2'b01);
    bus("pre-rst fire", 0, 16'h8000, 1'b1, 1'b0);
    @(negedge fclk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst imm", 32'(imm_nmi), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst hit_valid", 32'(hit_valid), 32'd0);
    @(posedge fclk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0;
      m_type[i] = '0;
      m_pcnt[i] = '0;
    end
    tick(0, 0);
    bus("post-rst off", 0, 16'h8000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
